// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for EX: latches operands, drives the shared mul and
// div units, stalls EX while busy and issues a single-cycle HI/LO write.
//
// state | meaning
// IDLE  | waiting for a mul/div instruction
// MUL   | multiplier inputs held, counting down the fixed pipeline latency
// DIV   | divider started, waiting for div_ready
// DONE  | result in hi_r/lo_r, writing HI/LO unless downstream holds
module md_sequencer #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        op_valid,
   input  logic [1:0]  op_type,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        ex_hold,
   input  logic        flush,
   output logic        mul_signed,
   output logic [31:0] mul_ina,
   output logic [31:0] mul_inb,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_opdata1,
   output logic [31:0] div_opdata2,
   output logic        div_annul,
   input  logic [63:0] div_result,
   input  logic        div_ready,
   output logic        stallreq,
   output logic        hilo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] a_r, b_r, hi_r, lo_r;
   logic        sgn_r;
   logic [2:0]  cnt;
   logic        accept;

   assign accept = (state == IDLE) && op_valid && !flush;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         hi_r  <= '0;
         lo_r  <= '0;
         sgn_r <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_r   <= src_a;
            b_r   <= src_b;
            sgn_r <= ~op_type[0];
            if (!op_type[1]) begin
               cnt <= 3'(MUL_LAT - 1);
            end else if (src_b == 32'd0) begin
               // divide by zero bypasses the divider entirely
               hi_r <= src_a;
               lo_r <= 32'hFFFF_FFFF;
            end
         end
         if (state == MUL && !flush) begin
            if (cnt == 3'd0) {hi_r, lo_r} <= mul_result;
            else             cnt <= cnt - 3'd1;
         end
         if (state == DIV && !flush && div_ready) {hi_r, lo_r} <= div_result;
      end
   end

   always_comb begin
      state_nxt   = state;
      mul_signed  = 1'b0;
      mul_ina     = '0;
      mul_inb     = '0;
      div_start   = 1'b0;
      div_signed  = 1'b0;
      div_opdata1 = '0;
      div_opdata2 = '0;
      div_annul   = 1'b0;
      stallreq    = 1'b0;
      hilo_we     = 1'b0;
      case (state)
         IDLE: begin
            stallreq = op_valid && !flush;
            if (accept) begin
               if (!op_type[1])          state_nxt = MUL;
               else if (src_b == 32'd0)  state_nxt = DONE;
               else                      state_nxt = DIV;
            end
         end
         MUL: begin
            stallreq   = 1'b1;
            mul_signed = sgn_r;
            mul_ina    = a_r;
            mul_inb    = b_r;
            if (flush)              state_nxt = IDLE;
            else if (cnt == 3'd0)   state_nxt = DONE;
         end
         DIV: begin
            stallreq    = 1'b1;
            div_signed  = sgn_r;
            div_opdata1 = a_r;
            div_opdata2 = b_r;
            div_start   = !div_ready;
            if (flush) begin
               div_annul = 1'b1;
               state_nxt = IDLE;
            end else if (div_ready) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (flush) begin
               state_nxt = IDLE;
            end else if (!ex_hold) begin
               hilo_we   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign hi_wdata = hi_r;
   assign lo_wdata = lo_r;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer with stub multiplier (MUL_LAT=2) and stub
// divider whose ready delay is programmable.
module tb_md_sequencer;

   logic        clk = 1'b0;
   logic        resetn, op_valid, ex_hold, flush;
   logic [1:0]  op_type;
   logic [31:0] src_a, src_b;
   logic        mul_signed, div_start, div_signed, div_annul, div_ready;
   logic        stallreq, hilo_we, busy;
   logic [31:0] mul_ina, mul_inb, div_opdata1, div_opdata2, hi_wdata, lo_wdata;
   logic [63:0] mul_result, div_result;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   md_sequencer #(.MUL_LAT(2)) dut (
      .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type),
      .src_a(src_a), .src_b(src_b), .ex_hold(ex_hold), .flush(flush),
      .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
      .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
      .div_opdata1(div_opdata1), .div_opdata2(div_opdata2), .div_annul(div_annul),
      .div_result(div_result), .div_ready(div_ready), .stallreq(stallreq),
      .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .busy(busy)
   );

   // multiplier stub: one register stage, product visible on the second MUL cycle
   logic [63:0] ext_a, ext_b;
   always_comb begin
      ext_a = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'd0, mul_ina};
      ext_b = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'd0, mul_inb};
   end
   always_ff @(posedge clk) mul_result <= ext_a * ext_b;

   // divider stub: ready after div_cyc cycles of div_start, or forced
   logic [7:0]  dcnt = 8'd0;
   logic [7:0]  div_cyc;
   logic        force_rdy;
   assign div_ready = (dcnt == div_cyc) || force_rdy;
   always_ff @(posedge clk) begin
      if (div_annul || div_ready) dcnt <= 8'd0;
      else if (div_start)         dcnt <= dcnt + 8'd1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1;
      op_type  = t;
      src_a    = a;
      src_b    = b;
      #1;
      chk("accept_stall", stallreq, 1'b1);
      tick();
      op_valid = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; op_valid = 1'b0; op_type = 2'b00; src_a = '0; src_b = '0;
      ex_hold = 1'b0; flush = 1'b0; div_cyc = 8'd34; force_rdy = 1'b0;
      div_result = 64'd0;
      tick(); tick();
      resetn = 1'b1;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_stall", stallreq, 1'b0);
      chk("rst_hilo_we", hilo_we, 1'b0);
      chk("rst_hilo", {hi_wdata, lo_wdata}, 64'd0);
      chk("rst_mul_in", {mul_ina, mul_inb}, 64'd0);
      chk("rst_div_start", div_start, 1'b0);

      // flush together with op_valid in IDLE: nothing accepted
      op_valid = 1'b1; op_type = 2'b00; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
      #1;
      chk("flush_idle_stall", stallreq, 1'b0);
      tick();
      op_valid = 1'b0; flush = 1'b0;
      chk("flush_idle_busy", busy, 1'b0);

      // 1: MULT -3 * 5
      issue(2'b00, 32'hFFFF_FFFD, 32'd5);
      chk("mult_t1_stall", stallreq, 1'b1);
      chk("mult_t1_ina", mul_ina, 32'hFFFF_FFFD);
      chk("mult_t1_inb", mul_inb, 32'd5);
      chk("mult_t1_signed", mul_signed, 1'b1);
      tick();
      chk("mult_t2_stall", stallreq, 1'b1);
      chk("mult_t2_we", hilo_we, 1'b0);
      tick();
      chk("mult_t3_we", hilo_we, 1'b1);
      chk("mult_t3_stall", stallreq, 1'b0);
      chk("mult_hi", hi_wdata, 32'hFFFF_FFFF);
      chk("mult_lo", lo_wdata, 32'hFFFF_FFF1);
      tick();
      chk("mult_after_busy", busy, 1'b0);
      chk("mult_after_we", hilo_we, 1'b0);
      chk("mult_after_ina", mul_ina, 32'd0);

      // 2: DIVU 100 / 7 -> {2,14}
      div_result = {32'd2, 32'd14};
      issue(2'b11, 32'd100, 32'd7);
      chk("divu_op1", div_opdata1, 32'd100);
      chk("divu_op2", div_opdata2, 32'd7);
      chk("divu_signed", div_signed, 1'b0);
      for (int i = 0; i < 34; i++) begin
         chk("divu_start_held", div_start, 1'b1);
         chk("divu_stall_held", stallreq, 1'b1);
         tick();
      end
      chk("divu_ready", div_ready, 1'b1);
      chk("divu_start_drop", div_start, 1'b0);
      chk("divu_ready_we", hilo_we, 1'b0);
      tick();
      chk("divu_we", hilo_we, 1'b1);
      chk("divu_stall_done", stallreq, 1'b0);
      chk("divu_hi", hi_wdata, 32'd2);
      chk("divu_lo", lo_wdata, 32'd14);
      tick();
      chk("divu_after_busy", busy, 1'b0);
      chk("divu_after_op1", div_opdata1, 32'd0);

      // 3: DIV by zero
      op_valid = 1'b1; op_type = 2'b10; src_a = 32'h1234; src_b = 32'd0;
      #1;
      chk("div0_start_t0", div_start, 1'b0);
      chk("div0_stall_t0", stallreq, 1'b1);
      tick();
      op_valid = 1'b0;
      chk("div0_start_t1", div_start, 1'b0);
      chk("div0_we", hilo_we, 1'b1);
      chk("div0_hi", hi_wdata, 32'h1234);
      chk("div0_lo", lo_wdata, 32'hFFFF_FFFF);
      tick();
      chk("div0_after_busy", busy, 1'b0);

      // 4: MULTU 0xFFFFFFFF * 2 with ex_hold for 3 cycles
      issue(2'b01, 32'hFFFF_FFFF, 32'd2);
      chk("multu_signed", mul_signed, 1'b0);
      tick();
      ex_hold = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("hold_we", hilo_we, 1'b0);
         chk("hold_busy", busy, 1'b1);
         chk("hold_hilo", {hi_wdata, lo_wdata}, 64'h1_FFFF_FFFE);
         tick();
      end
      ex_hold = 1'b0;
      #1;
      chk("hold_release_we", hilo_we, 1'b1);
      chk("hold_release_hilo", {hi_wdata, lo_wdata}, 64'h1_FFFF_FFFE);
      tick();
      chk("hold_after_we", hilo_we, 1'b0);
      chk("hold_after_busy", busy, 1'b0);

      // 5: DIV flushed at cycle 10 with div_ready in the same cycle
      div_cyc = 8'd200;
      div_result = {32'd0, 32'd10};
      issue(2'b10, 32'd50, 32'd5);
      chk("div_signed", div_signed, 1'b1);
      for (int i = 1; i < 10; i++) begin
         chk("flush_pre_annul", div_annul, 1'b0);
         tick();
      end
      flush = 1'b1; force_rdy = 1'b1;
      #1;
      chk("flush_annul", div_annul, 1'b1);
      chk("flush_we", hilo_we, 1'b0);
      tick();
      flush = 1'b0; force_rdy = 1'b0;
      #1;
      chk("flush_next_busy", busy, 1'b0);
      chk("flush_next_annul", div_annul, 1'b0);
      chk("flush_next_we", hilo_we, 1'b0);
      chk("flush_next_start", div_start, 1'b0);
      tick();
      chk("flush_later_we", hilo_we, 1'b0);

      // 6: reset mid-MUL, then MULT 6*7
      issue(2'b00, 32'd2, 32'd3);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_stall", stallreq, 1'b0);
      chk("midrst_ina", mul_ina, 32'd0);
      chk("midrst_hilo", {hi_wdata, lo_wdata}, 64'd0);
      chk("midrst_we", hilo_we, 1'b0);
      issue(2'b00, 32'd6, 32'd7);
      tick();
      tick();
      chk("post_rst_we", hilo_we, 1'b1);
      chk("post_rst_hi", hi_wdata, 32'd0);
      chk("post_rst_lo", lo_wdata, 32'd42);
      tick();
      chk("post_rst_idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Sequences the shared multiplier (fixed latency, pipelined) and the iterative divider (start/ready handshake) used by MULT/MULTU/DIV/DIVU in the EX stage.
- Latches operands and drives the unit inputs. Raises the EX stall request while an operation is in flight.
- Delivers a single-cycle HI/LO write when the result is ready, and handles flush and downstream hold.
- EX instantiates it in place of the inline mul/div stall logic. Its stallreq feeds stallreq_for_ex.

Parameters:
- MUL_LAT, 2, cycles from mul_ina/mul_inb stable to mul_result valid; legal range 1..7.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- op_valid  in  1  EX holds a mul/div instruction this cycle
- op_type  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- ex_hold  in  1  downstream (MEM) stalled; EX result cannot advance this cycle
- flush  in  1  kill the in-flight operation
- mul_signed  out  1  to mul unit
- mul_ina  out  32  to mul unit
- mul_inb  out  32  to mul unit
- mul_result  in  64  from mul unit
- div_start  out  1  to div unit
- div_signed  out  1  to div unit
- div_opdata1  out  32  to div unit, dividend
- div_opdata2  out  32  to div unit, divisor
- div_annul  out  1  to div unit, abort
- div_result  in  64  {remainder, quotient}
- div_ready  in  1  one-cycle pulse, div_result valid
- stallreq  out  1  request EX stall
- hilo_we  out  1  write HI and LO this cycle
- hi_wdata  out  32  HI write data
- lo_wdata  out  32  LO write data
- busy  out  1  state != IDLE

Behaviour:
- Reset (resetn=0 at a rising edge)
  - state <= IDLE; operand, result and counter registers <= 0.
  - All outputs are 0 during and after reset until a new op is accepted.
  - Reset mid-operation abandons it silently. div_annul is not required during reset.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE
  - Op is accepted when op_valid=1 and flush=0.
  - On accept: capture a_r=src_a, b_r=src_b, type_r=op_type.
  - MULT/MULTU: go to MUL; cnt <= MUL_LAT-1.
  - DIV/DIVU with src_b!=0: go to DIV.
  - DIV/DIVU with src_b==0: go directly to DONE with hi_r=src_a, lo_r=32'hFFFF_FFFF. The divider is not started.
  - stallreq = op_valid & ~flush (combinational) in the accept cycle.
- MUL
  - mul_ina=a_r, mul_inb=b_r, mul_signed=~type_r[0]. These hold stable for the whole state.
  - Each cycle: cnt decrements. When cnt==0, capture {hi_r,lo_r}=mul_result and go to DONE.
  - stallreq=1 throughout.
- DIV
  - div_opdata1=a_r, div_opdata2=b_r, div_signed=~type_r[0], div_start=1, all held until div_ready.
  - On div_ready=1: capture hi_r=div_result[63:32], lo_r=div_result[31:0]; div_start=0 in that cycle; go to DONE.
  - stallreq=1 throughout.
- DONE
  - stallreq=0; hi_wdata=hi_r and lo_wdata=lo_r (these are held in all states except reset).
  - ex_hold=0: hilo_we=1 for exactly this cycle, then go to IDLE. The EX register advances at this edge, so the same instruction is never reissued.
  - ex_hold=1: hilo_we=0; remain in DONE with the result held.
- Latency (accept cycle = T)
  - Multiply: DONE and hilo_we at T+MUL_LAT+1 (T+3 at default). stallreq high T..T+MUL_LAT.
  - Divide: DONE one cycle after the div_ready cycle.
  - Divide by zero: DONE at T+1.
- Unit input gating: outside MUL, mul_* outputs are 0. Outside DIV, div_start, div_signed and div_opdata* are 0.
- Flush
  - Takes priority over every transition: next state IDLE, no hilo_we in that cycle or later.
  - If the state is DIV, div_annul=1 for that cycle only.
  - If flush and op_valid arrive together in IDLE, nothing is accepted and stallreq=0.
- Simultaneous events
  - div_ready together with flush: the result is discarded.
  - op_valid while not in IDLE: ignored, because EX is stalled and it is the same instruction.
- Width rules
  - MULTU and DIVU treat operands as unsigned 32-bit.
  - Signed overflow (0x80000000 / -1) is passed through from the divider unmodified.

Test Plan:
1. MULT src_a=-3 (0xFFFFFFFD), src_b=5, MUL_LAT=2, stub multiplier returns the product after 2 cycles -> stallreq high 3 cycles; at T+3 hilo_we=1, hi_wdata=0xFFFFFFFF, lo_wdata=0xFFFFFFF1.
2. DIVU src_a=100, src_b=7, stub divider pulses div_ready 34 cycles after start with {2,14} -> div_start held 34 cycles with opdata 100/7; next cycle hilo_we=1, hi=2, lo=14; stallreq low in that cycle.
3. DIV src_b=0, src_a=0x1234 -> no div_start ever; T+1 hilo_we=1, hi=0x1234, lo=0xFFFFFFFF.
4. MULTU 0xFFFFFFFF*2 with ex_hold=1 for 3 cycles on reaching DONE -> hilo_we stays 0 while held, hi=1/lo=0xFFFFFFFE stable; exactly one hilo_we pulse when ex_hold drops; then IDLE.
5. DIV in progress, flush at cycle 10 -> div_annul one-cycle pulse, state IDLE next cycle, no hilo_we even if div_ready arrives the same cycle.
6. resetn=0 asserted mid-MUL for 1 cycle -> all outputs 0 next cycle, busy=0; a new MULT 6*7 afterwards gives lo=42, hi=0.
